// File: rtl/keyboard_pkg.sv
// Shared keycode types, reserved HID keycodes and the slot-tracker FSM states.
package keyboard_pkg;
  typedef logic [7:0] keycode_t;

  localparam keycode_t KEYCODE_NONE         = 8'h00;
  localparam keycode_t KEYCODE_ERR_ROLLOVER = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    RELEASE,
    ASSIGN
  } state_t;
endpackage

// File: rtl/free_slot_select.sv
// Combinational pick of the lowest-index free slot; with KEY_STEAL_EN also the oldest-assigned slot.
// Zero latency, no flow control.
module free_slot_select #(
  parameter int NUMREADS = 4,
  parameter int AW       = (NUMREADS > 1) ? $clog2(NUMREADS) : 1
) (
  input  logic [NUMREADS-1:0] i_gate,
`ifdef KEY_STEAL_EN
  input  logic [AW-1:0]       i_age [NUMREADS],
  output logic [AW-1:0]       o_old_idx,
`endif
  output logic                o_free_vld,
  output logic [AW-1:0]       o_free_idx
);

  always_comb begin
    o_free_vld = 1'b0;
    o_free_idx = '0;
    for (int i = NUMREADS - 1; i >= 0; i--) begin
      if (!i_gate[i]) begin
        o_free_vld = 1'b1;
        o_free_idx = AW'(i);
      end
    end
  end

`ifdef KEY_STEAL_EN
  // Ages form a permutation of 0..NUMREADS-1, so exactly one slot holds the top rank.
  always_comb begin
    o_old_idx = '0;
    for (int i = 0; i < NUMREADS; i++) begin
      if (i_age[i] == AW'(NUMREADS - 1)) o_old_idx = AW'(i);
    end
  end
`endif

endmodule

// File: rtl/key_slot_tracker.sv
// Maps held HID boot-report keys onto NUMREADS note slots (gate/keycode/rden); optional KEY_STEAL_EN steals the oldest slot.
// One report per NUMKEYS+3 cycles; report_ready is low outside IDLE and the upstream stage holds its report.
module key_slot_tracker
  import keyboard_pkg::*;
#(
  parameter int NUMREADS = 4,
  parameter int NUMKEYS  = 6
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_report_valid,
  input  keycode_t            i_report_keycodes [NUMKEYS],
  output logic                o_report_ready,
  output keycode_t            o_keycodes [NUMREADS],
  output logic [NUMREADS-1:0] o_rden,
  output logic [NUMREADS-1:0] o_gate,
  output logic                o_key_dropped
);

  localparam int AW = (NUMREADS > 1) ? $clog2(NUMREADS) : 1;
  localparam int KW = (NUMKEYS > 1) ? $clog2(NUMKEYS) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  keycode_t            r_report [NUMKEYS];
  logic [KW-1:0]       r_k;
  keycode_t            r_keycodes [NUMREADS];
  logic [NUMREADS-1:0] r_gate;
  logic [NUMREADS-1:0] r_rden_d;
  logic [NUMREADS-1:0] r_rden;
  logic                r_key_dropped;

  logic                w_rollover;
  logic [NUMREADS-1:0] w_held;
  logic [NUMREADS-1:0] w_dup_hit;
  keycode_t            w_byte;
  logic                w_skip;
  logic                w_free_vld;
  logic [AW-1:0]       w_free_idx;
  logic [AW-1:0]       w_tgt_idx;
  logic                w_take;
  logic                w_drop;
  logic [NUMREADS-1:0] w_rden_set;

  always_comb begin
    w_rollover = 1'b0;
    for (int k = 0; k < NUMKEYS; k++) begin
      if (r_report[k] == KEYCODE_ERR_ROLLOVER) w_rollover = 1'b1;
    end
  end

  always_comb begin
    w_held = '0;
    for (int i = 0; i < NUMREADS; i++) begin
      for (int k = 0; k < NUMKEYS; k++) begin
        if (r_gate[i] && (r_keycodes[i] == r_report[k])) w_held[i] = 1'b1;
      end
    end
  end

  assign w_byte = r_report[r_k];

  // Covers keys held from the previous report and ones assigned earlier in this report.
  always_comb begin
    w_dup_hit = '0;
    for (int i = 0; i < NUMREADS; i++) begin
      w_dup_hit[i] = r_gate[i] && (r_keycodes[i] == w_byte);
    end
  end

  assign w_skip = (w_byte == KEYCODE_NONE) || (|w_dup_hit);

`ifdef KEY_STEAL_EN
  logic [AW-1:0] r_age [NUMREADS];
  logic [AW-1:0] w_old_idx;

  assign w_take    = (r_state == ASSIGN) && !w_skip;
  assign w_drop    = 1'b0;
  assign w_tgt_idx = w_free_vld ? w_free_idx : w_old_idx;

  // Least-recently-assigned ranking: the target drops to rank 0, younger slots age by one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUMREADS; i++) r_age[i] <= AW'(NUMREADS - 1 - i);
    end else if (w_take) begin
      for (int i = 0; i < NUMREADS; i++) begin
        if (AW'(i) == w_tgt_idx) r_age[i] <= '0;
        else if (r_age[i] < r_age[w_tgt_idx]) r_age[i] <= r_age[i] + AW'(1);
      end
    end
  end

  free_slot_select #(.NUMREADS(NUMREADS), .AW(AW)) u_free_slot_select (
    .i_gate     (r_gate),
    .i_age      (r_age),
    .o_old_idx  (w_old_idx),
    .o_free_vld (w_free_vld),
    .o_free_idx (w_free_idx)
  );
`else
  assign w_take    = (r_state == ASSIGN) && !w_skip && w_free_vld;
  assign w_drop    = (r_state == ASSIGN) && !w_skip && !w_free_vld;
  assign w_tgt_idx = w_free_idx;

  free_slot_select #(.NUMREADS(NUMREADS), .AW(AW)) u_free_slot_select (
    .i_gate     (r_gate),
    .o_free_vld (w_free_vld),
    .o_free_idx (w_free_idx)
  );
`endif

  // A slot re-pressed with the key it already owns gets its gate back but no lookup strobe.
  assign w_rden_set = (w_take && (r_keycodes[w_tgt_idx] != w_byte)) ?
                      (NUMREADS'(1) << w_tgt_idx) : '0;

  always_comb begin
    w_state_nxt    = r_state;
    o_report_ready = 1'b0;
    case (r_state)
      IDLE: begin
        o_report_ready = 1'b1;
        if (i_report_valid) w_state_nxt = LATCH;
      end
      LATCH:   w_state_nxt = w_rollover ? IDLE : RELEASE;
      RELEASE: w_state_nxt = ASSIGN;
      ASSIGN:  if (r_k == KW'(NUMKEYS - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_k           <= '0;
      r_gate        <= '0;
      r_rden_d      <= '0;
      r_rden        <= '0;
      r_key_dropped <= 1'b0;
      for (int i = 0; i < NUMREADS; i++) r_keycodes[i] <= KEYCODE_NONE;
      for (int k = 0; k < NUMKEYS; k++) r_report[k] <= KEYCODE_NONE;
    end else begin
      r_state       <= w_state_nxt;
      r_rden_d      <= w_rden_set;
      r_rden        <= r_rden_d;
      r_key_dropped <= w_drop;
      if ((r_state == IDLE) && i_report_valid) r_report <= i_report_keycodes;
      if (r_state == RELEASE) begin
        r_gate <= r_gate & w_held;
        r_k    <= '0;
      end
      if (r_state == ASSIGN) begin
        r_k <= r_k + KW'(1);
        if (w_take) begin
          r_keycodes[w_tgt_idx] <= w_byte;
          r_gate[w_tgt_idx]     <= 1'b1;
        end
      end
    end
  end

  assign o_keycodes    = r_keycodes;
  assign o_gate        = r_gate;
  assign o_rden        = r_rden;
  assign o_key_dropped = r_key_dropped;

endmodule

// File: tb/tb_key_slot_tracker.sv
// Bench for key_slot_tracker: directed table, random reports against a slot-map model, reset mid-report.
module tb_key_slot_tracker;
  import keyboard_pkg::*;

  localparam int NR = 4;
  localparam int NK = 6;
  localparam int TR = NK + 6;

  typedef struct packed {
    logic [NK*8-1:0] keys;
    logic [31:0]     kc;
    logic [NR-1:0]   gate;
    logic [NR-1:0]   rden;
    logic [3:0]      nrden;
    logic [3:0]      drops;
    logic [4:0]      low;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          report_valid = 1'b0;
  keycode_t      report_keycodes [NK];
  logic          report_ready;
  keycode_t      keycodes [NR];
  logic [NR-1:0] rden;
  logic [NR-1:0] gate;
  logic          key_dropped;

  int errors = 0;
  int checks = 0;

  logic [NR-1:0] tr_rden [TR];
  logic [NR-1:0] tr_gate [TR];
  logic [TR-1:0] tr_drop;
  logic [TR-1:0] tr_ready;

  keycode_t      m_kc [NR];
  logic [NR-1:0] m_gate;
  int            m_stamp [NR];
  int            m_time;
  bit            e_roll;
  int            e_rden_slot [NK];
  bit            e_drop [NK];
  logic [NR-1:0] e_gate_rel;

  key_slot_tracker #(.NUMREADS(NR), .NUMKEYS(NK)) dut (
    .i_clk             (clk),
    .i_reset_n         (reset_n),
    .i_report_valid    (report_valid),
    .i_report_keycodes (report_keycodes),
    .o_report_ready    (report_ready),
    .o_keycodes        (keycodes),
    .o_rden            (rden),
    .o_gate            (gate),
    .o_key_dropped     (key_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [NK*8-1:0] mk(input keycode_t b0, b1, b2, b3, b4, b5);
    return {b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic logic [31:0] dut_kc();
    logic [31:0] r;
    for (int i = 0; i < NR; i++) r[8*i +: 8] = keycodes[i];
    return r;
  endfunction

  function automatic logic [31:0] model_kc();
    logic [31:0] r;
    for (int i = 0; i < NR; i++) r[8*i +: 8] = m_kc[i];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_kc[i]    = 8'h00;
      m_stamp[i] = 0;
    end
    m_gate = '0;
    m_time = 0;
  endfunction

  // Slot-map semantics of one report: release absent keys, then place new keys byte by byte.
  function automatic void model(input logic [NK*8-1:0] keys);
    keycode_t b;
    int       s;
    bit       found;
    e_roll = 0;
    for (int k = 0; k < NK; k++) begin
      e_rden_slot[k] = -1;
      e_drop[k]      = 0;
      if (keys[8*k +: 8] == 8'h01) e_roll = 1;
    end
    if (!e_roll) begin
      for (int i = 0; i < NR; i++) begin
        found = 0;
        for (int k = 0; k < NK; k++) if (keys[8*k +: 8] == m_kc[i]) found = 1;
        if (m_gate[i] && !found) m_gate[i] = 1'b0;
      end
    end
    e_gate_rel = m_gate;
    if (e_roll) return;
    for (int k = 0; k < NK; k++) begin
      b = keys[8*k +: 8];
      if (b == 8'h00) continue;
      found = 0;
      for (int i = 0; i < NR; i++) if (m_gate[i] && m_kc[i] == b) found = 1;
      if (found) continue;
      s = -1;
      for (int i = NR - 1; i >= 0; i--) if (!m_gate[i]) s = i;
      if (s < 0) begin
`ifdef KEY_STEAL_EN
        s = 0;
        for (int i = 1; i < NR; i++) if (m_stamp[i] < m_stamp[s]) s = i;
`else
        e_drop[k] = 1;
        continue;
`endif
      end
      if (m_kc[s] != b) e_rden_slot[k] = s;
      m_kc[s]    = b;
      m_gate[s]  = 1'b1;
      m_time++;
      m_stamp[s] = m_time;
    end
  endfunction

  // Presents one report and records outputs for TR cycles following the accepting edge.
  task automatic send(input logic [NK*8-1:0] keys);
    int n = 0;
    @(negedge clk);
    while (report_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (report_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got=%b want=1", report_ready);
    end
    for (int k = 0; k < NK; k++) report_keycodes[k] = keys[8*k +: 8];
    report_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < TR; c++) begin
      @(negedge clk);
      if (c == 0) begin
        report_valid = 1'b0;
        for (int k = 0; k < NK; k++) report_keycodes[k] = 8'($urandom);
      end
      tr_rden[c]  = rden;
      tr_gate[c]  = gate;
      tr_drop[c]  = key_dropped;
      tr_ready[c] = report_ready;
    end
  endtask

  task automatic check_vs_model();
    logic [TR-1:0] exp_ready;
    logic [TR-1:0] exp_drop;
    logic [NR-1:0] exp_r;
    int            low;
    low = e_roll ? 1 : NK + 2;
    for (int c = 0; c < TR; c++) begin
      exp_ready[c] = (c >= low);
      exp_drop[c]  = (c >= 3) && (c < 3 + NK) && e_drop[c-3];
      exp_r = '0;
      if (c >= 4 && c < 4 + NK && e_rden_slot[c-4] >= 0) exp_r[e_rden_slot[c-4]] = 1'b1;
      chk($sformatf("rden_cycle%0d", c), 64'(tr_rden[c]), 64'(exp_r));
    end
    chk("ready_trace", 64'(tr_ready), 64'(exp_ready));
    chk("drop_trace", 64'(tr_drop), 64'(exp_drop));
    chk("gate_after_release", 64'(tr_gate[2]), 64'(e_gate_rel));
    chk("keycodes", 64'(dut_kc()), 64'(model_kc()));
    chk("gate", 64'(gate), 64'(m_gate));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t            tbl [9];
  logic [NK*8-1:0] keys;
  logic [NR-1:0]   mask;
  int              nr, nd, nlow;

  initial begin
    for (int k = 0; k < NK; k++) report_keycodes[k] = 8'h00;
    tbl[0] = '{mk(8'h04, 0, 0, 0, 0, 0), 32'h0000_0004, 4'b0001, 4'b0001, 4'd1, 4'd0, 5'd8};
    tbl[1] = '{mk(8'h04, 8'h16, 0, 0, 0, 0), 32'h0000_1604, 4'b0011, 4'b0010, 4'd1, 4'd0, 5'd8};
    tbl[2] = '{mk(8'h16, 0, 0, 0, 0, 0), 32'h0000_1604, 4'b0010, 4'b0000, 4'd0, 4'd0, 5'd8};
    tbl[3] = '{mk(8'h07, 8'h16, 0, 0, 0, 0), 32'h0000_1607, 4'b0011, 4'b0001, 4'd1, 4'd0, 5'd8};
    tbl[4] = '{mk(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 32'h0000_1607, 4'b0011, 4'b0000, 4'd0, 4'd0, 5'd1};
    tbl[5] = '{mk(8'h09, 8'h09, 0, 0, 0, 0), 32'h0000_1609, 4'b0001, 4'b0001, 4'd1, 4'd0, 5'd8};
    tbl[6] = '{mk(0, 0, 0, 0, 0, 0), 32'h0000_1609, 4'b0000, 4'b0000, 4'd0, 4'd0, 5'd8};
    tbl[7] = '{mk(8'h09, 0, 0, 0, 0, 0), 32'h0000_1609, 4'b0001, 4'b0000, 4'd0, 4'd0, 5'd8};
`ifdef KEY_STEAL_EN
    tbl[8] = '{mk(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F), 32'h0D0C_0F0E, 4'b1111, 4'b1111, 4'd6, 4'd0, 5'd8};
`else
    tbl[8] = '{mk(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F), 32'h0D0C_0B0A, 4'b1111, 4'b1111, 4'd4, 4'd2, 5'd8};
`endif

    #12;
    chk("reset_ready", 64'(report_ready), 64'd1);
    chk("reset_gate", 64'(gate), 64'd0);
    chk("reset_rden", 64'(rden), 64'd0);
    chk("reset_drop", 64'(key_dropped), 64'd0);
    chk("reset_keycodes", 64'(dut_kc()), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      send(tbl[t].keys);
      mask = '0; nr = 0; nd = 0; nlow = 0;
      for (int c = 0; c < TR; c++) begin
        mask |= tr_rden[c];
        nr += $countones(tr_rden[c]);
        if ($countones(tr_rden[c]) > 1) chk($sformatf("tbl%0d_rden_onehot", t), 64'(tr_rden[c]), 64'(0));
        nd += int'(tr_drop[c]);
        if (!tr_ready[c]) nlow++;
      end
      chk($sformatf("tbl%0d_keycodes", t), 64'(dut_kc()), 64'(tbl[t].kc));
      chk($sformatf("tbl%0d_gate", t), 64'(gate), 64'(tbl[t].gate));
      chk($sformatf("tbl%0d_rden_mask", t), 64'(mask), 64'(tbl[t].rden));
      chk($sformatf("tbl%0d_rden_count", t), 64'(nr), 64'(tbl[t].nrden));
      chk($sformatf("tbl%0d_drops", t), 64'(nd), 64'(tbl[t].drops));
      chk($sformatf("tbl%0d_busy_cycles", t), 64'(nlow), 64'(tbl[t].low));
    end

    do_reset();
    model_reset();
    for (int r = 0; r < 80; r++) begin
      if (r > 0 && $urandom_range(0, 5) == 0) begin
        // keep the previous report: held keys must stay put
      end else begin
        for (int k = 0; k < NK; k++) begin
          nr = $urandom_range(0, 15);
          keys[8*k +: 8] = (nr < 5) ? 8'h00 : 8'(8'h03 + nr);
        end
        if ($urandom_range(0, 19) == 0) keys[8*$urandom_range(0, NK-1) +: 8] = 8'h01;
      end
      model(keys);
      send(keys);
      check_vs_model();
    end

    do_reset();
    model_reset();
    @(negedge clk);
    for (int k = 0; k < NK; k++) report_keycodes[k] = 8'h00;
    report_keycodes[0] = 8'h11;
    report_keycodes[1] = 8'h12;
    report_keycodes[2] = 8'h13;
    report_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      report_valid = 1'b0;
    end
    chk("midrst_pre_rden", 64'(rden), 64'b0001);
    chk("midrst_pre_gate", 64'(gate), 64'b0011);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(report_ready), 64'd1);
    chk("midrst_gate", 64'(gate), 64'd0);
    chk("midrst_rden", 64'(rden), 64'd0);
    chk("midrst_drop", 64'(key_dropped), 64'd0);
    chk("midrst_keycodes", 64'(dut_kc()), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(report_ready), 64'd1);
    keys = mk(8'h22, 0, 0, 0, 0, 0);
    model(keys);
    send(keys);
    check_vs_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
